// File: rtl/scan_test_controller.sv
// Full-scan test sequencer: per pattern load chain, one capture cycle, unload overlapped with next load.
// Optional SCAN_MISR_EN adds a 16-bit response MISR (x^16+x^12+x^5+1) on the signature port.
module scan_test_controller #(
    parameter int CHAIN_LEN    = 3,
    parameter int MAX_PATTERNS = 16,
    parameter int CNT_W        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_patterns,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_pi,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    input  logic                 scan_out,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 dut_inp,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     pat_idx,
    output logic [15:0]          signature
);
    localparam int PTR_W = $clog2(CHAIN_LEN);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PATTERNS);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CAPTURE, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [CNT_W-1:0]     pat_idx_q, pat_idx_d;
    logic [CNT_W-1:0]     fail_count_q, fail_count_d;
    logic [CHAIN_LEN-1:0] load_q, load_d;
    logic [CHAIN_LEN-1:0] load_exp_q, load_exp_d;
    logic [CHAIN_LEN-1:0] pend_exp_q, pend_exp_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 load_pi_q, load_pi_d;
    logic                 pend_q, pend_d;
    logic                 fail_q, fail_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 scan_enable_q, scan_enable_d;
    logic                 scan_in_q, scan_in_d;
    logic                 dut_inp_q, dut_inp_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 unload, compare;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        num_d        = num_q;
        pat_idx_d    = pat_idx_q;
        fail_count_d = fail_count_q;
        load_d       = load_q;
        load_exp_d   = load_exp_q;
        load_pi_d    = load_pi_q;
        pend_exp_d   = pend_exp_q;
        resp_d       = resp_q;
        pend_d       = pend_q;
        fail_d       = fail_q;
        done_d       = 1'b0;
        unload       = 1'b0;
        compare      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fail_d       = 1'b0;
                    fail_count_d = '0;
                    pat_idx_d    = '0;
                    pend_d       = 1'b0;
                    num_d        = (num_patterns > MAX_CNT) ? MAX_CNT : num_patterns;
                    if (num_patterns == '0) done_d = 1'b1;
                    else                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (pat_valid) begin
                    load_d     = pat_data;
                    load_pi_d  = pat_pi;
                    load_exp_d = pat_exp;
                    ptr_d      = PTR_TOP;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Unload of the previous response rides along with the load.
                unload = pend_q;
                if (ptr_q == '0) begin
                    compare = pend_q;
                    state_d = CAPTURE;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end
            CAPTURE: begin
                pend_d     = 1'b1;
                pend_exp_d = load_exp_q;
                pat_idx_d  = pat_idx_q + 1'b1;
                if (pat_idx_d == num_q) begin
                    ptr_d   = PTR_TOP;
                    state_d = FLUSH;
                end else begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                unload = 1'b1;
                if (ptr_q == '0) begin
                    compare = 1'b1;
                    pend_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (unload) resp_d[ptr_q] = scan_out;
        if (compare && (resp_d != pend_exp_q)) begin
            fail_d = 1'b1;
            if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
        end

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        pat_ready_d   = (state_d == FETCH);
        scan_enable_d = (state_d == SHIFT) || (state_d == FLUSH);
        scan_in_d     = (state_d == SHIFT) && load_d[ptr_d];
        dut_inp_d     = (state_d == CAPTURE) && load_pi_q;
        busy_d        = state_d inside {FETCH, SHIFT, CAPTURE, FLUSH};
        if (state_d == DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            num_q         <= '0;
            pat_idx_q     <= '0;
            fail_count_q  <= '0;
            load_q        <= '0;
            load_exp_q    <= '0;
            load_pi_q     <= 1'b0;
            pend_exp_q    <= '0;
            resp_q        <= '0;
            pend_q        <= 1'b0;
            fail_q        <= 1'b0;
            pat_ready_q   <= 1'b0;
            scan_enable_q <= 1'b0;
            scan_in_q     <= 1'b0;
            dut_inp_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            num_q         <= num_d;
            pat_idx_q     <= pat_idx_d;
            fail_count_q  <= fail_count_d;
            load_q        <= load_d;
            load_exp_q    <= load_exp_d;
            load_pi_q     <= load_pi_d;
            pend_exp_q    <= pend_exp_d;
            resp_q        <= resp_d;
            pend_q        <= pend_d;
            fail_q        <= fail_d;
            pat_ready_q   <= pat_ready_d;
            scan_enable_q <= scan_enable_d;
            scan_in_q     <= scan_in_d;
            dut_inp_q     <= dut_inp_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pat_ready   = pat_ready_q;
    assign scan_enable = scan_enable_q;
    assign scan_in     = scan_in_q;
    assign dut_inp     = dut_inp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_count  = fail_count_q;
    assign pat_idx     = pat_idx_q;

`ifdef SCAN_MISR_EN
    logic [15:0] misr_q, misr_d;

    always_comb begin
        misr_d = misr_q;
        if (state_q == IDLE && start) begin
            misr_d = 16'hFFFF;
        end else if (unload) begin
            misr_d = {misr_q[14:0], 1'b0} ^ ((misr_q[15] ^ scan_out) ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misr_q <= '0;
        else      misr_q <= misr_d;
    end

    assign signature = misr_q;
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: a 3-flop scan FSM stand-in with injectable stuck-at-0 flops,
// random ATPG-style patterns, and an arithmetic reference for responses, fail counts and MISR.
module tb_scan_test_controller;
    localparam int N  = 3;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_patterns = '0;
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [N-1:0]  pat_data = '0;
    logic          pat_pi = 1'b0;
    logic [N-1:0]  pat_exp = '0;
    logic          scan_out;
    logic          scan_enable, scan_in, dut_inp, busy, done, fail;
    logic [CW-1:0] fail_count, pat_idx;
    logic [15:0]   signature;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] pd [16];
    logic         ppi[16];
    logic [N-1:0] pex[16];

    // Chain under test: shift when scan_enable, one functional step right after a shift burst, else hold.
    logic [N-1:0] ff = '0;
    logic [N-1:0] chain_nxt;
    logic [N-1:0] stuck_mask = '0;
    logic         prev_se = 1'b0;

    always_comb begin
        chain_nxt = ff;
        if (scan_enable)  chain_nxt = {ff[N-2:0], scan_in};
        else if (prev_se) chain_nxt = {dut_inp, ff[N-1:1]};
        chain_nxt = chain_nxt & ~stuck_mask;
    end

    always @(posedge clk) begin
        ff      <= chain_nxt;
        prev_se <= scan_enable;
    end

    assign scan_out = ff[N-1];

    always #5 clk = ~clk;

    scan_test_controller #(.CHAIN_LEN(N), .MAX_PATTERNS(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
        .pat_pi(pat_pi), .pat_exp(pat_exp), .scan_out(scan_out),
        .scan_enable(scan_enable), .scan_in(scan_in), .dut_inp(dut_inp),
        .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
        .pat_idx(pat_idx), .signature(signature)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response seen at scan_out for one pattern; k = stuck-at-0 flop (-1 = none).
    // Bits loaded at/after k never arrive, and bits at/before k are zeroed on the way out.
    function automatic logic [N-1:0] ref_resp(input logic [N-1:0] d, input logic pi, input int k);
        logic [N-1:0] st, cap, r;
        for (int i = 0; i < N; i++) st[i] = (k < 0 || i < k) ? d[i] : 1'b0;
        cap = {pi, st[N-1:1]};
        for (int i = 0; i < N; i++) r[i] = (k >= 0 && i <= k) ? 1'b0 : cap[i];
        return r;
    endfunction

    task automatic fill(input int n, input int flip_pct);
        for (int p = 0; p < n; p++) begin
            pd[p]  = N'($urandom);
            ppi[p] = 1'($urandom);
            pex[p] = ref_resp(pd[p], ppi[p], -1);
            if ($urandom_range(99) < flip_pct) pex[p] = pex[p] ^ N'($urandom_range(1, (1 << N) - 1));
        end
    endtask

    logic [CW-1:0] last_fc;
    logic [15:0]   last_sig;

    task automatic do_run(input int n, input int stall_at, input int stall_len, input int fk,
                          input bit stray, input string tag);
        logic        sin_q[$];
        logic        dinp_q[$];
        int          idx, stalled, done_k, bad_busy, bad_inp, bad_se, bad_sin, bad_cap, exp_k, exp_fail;
        logic        rdy, prv;
        logic [N-1:0] r;
        logic [15:0] misr;
        stuck_mask = (fk >= 0) ? (N'(1) << fk) : '0;
        idx = 0; stalled = 0; done_k = -1; bad_busy = 0; bad_inp = 0; bad_se = 0; prv = 1'b0;
        start = 1'b1;
        num_patterns = CW'(n);
        pat_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (done) begin done_k = k; break; end
            if (!busy) bad_busy++;
            if (scan_enable) sin_q.push_back(scan_in);
            if (prv && !scan_enable) dinp_q.push_back(dut_inp);
            else if (dut_inp) bad_inp++;
            prv = scan_enable;
            if (stray && k == 3) begin start = 1'b1; num_patterns = '0; end
            else start = 1'b0;
            if (pat_ready && idx == stall_at && stalled < stall_len) begin
                pat_valid = 1'b0;
                stalled++;
                if (scan_enable) bad_se++;
            end else begin
                pat_valid = (idx < n);
                if (idx < n) begin
                    pat_data = pd[idx]; pat_pi = ppi[idx]; pat_exp = pex[idx];
                end
            end
            rdy = pat_ready;
            @(posedge clk); #1;
            if (rdy && pat_valid) idx++;
        end
        start = 1'b0;
        pat_valid = 1'b0;

        exp_fail = 0;
        misr = 16'hFFFF;
        for (int p = 0; p < n; p++) begin
            r = ref_resp(pd[p], ppi[p], fk);
            if (r !== pex[p]) exp_fail++;
            for (int b = N - 1; b >= 0; b--)
                misr = {misr[14:0], 1'b0} ^ ((misr[15] ^ r[b]) ? 16'h1021 : 16'h0000);
        end
        exp_k = (n == 0) ? 1 : n * (N + 2) + N + 1 + ((stall_at < n) ? stall_len : 0);

        bad_sin = (sin_q.size() == ((n == 0) ? 0 : (n + 1) * N)) ? 0 : 1000;
        if (bad_sin == 0) begin
            for (int p = 0; p < n; p++)
                for (int j = 0; j < N; j++)
                    if (sin_q[p * N + j] !== pd[p][N - 1 - j]) bad_sin++;
            for (int j = n * N; j < sin_q.size(); j++)
                if (sin_q[j] !== 1'b0) bad_sin++;
        end
        bad_cap = (dinp_q.size() == n) ? 0 : 1000;
        if (bad_cap == 0)
            for (int p = 0; p < n; p++) if (dinp_q[p] !== ppi[p]) bad_cap++;

        check({tag, " done_cycle"}, done_k, exp_k);
        check({tag, " fail_count"}, 32'(fail_count), exp_fail);
        check({tag, " fail"}, 32'(fail), (exp_fail > 0) ? 1 : 0);
        check({tag, " pat_idx"}, 32'(pat_idx), n);
        check({tag, " busy_at_done"}, 32'(busy), 0);
        check({tag, " busy_during_run"}, bad_busy, 0);
        check({tag, " scan_in_stream"}, bad_sin, 0);
        check({tag, " capture_inputs"}, bad_cap + bad_inp, 0);
        if (stall_at < n) check({tag, " stall_scan_enable"}, bad_se + (stalled - stall_len), 0);
`ifdef SCAN_MISR_EN
        check({tag, " signature"}, 32'(signature), 32'(misr));
`else
        check({tag, " signature"}, 32'(signature), 0);
`endif
        last_fc  = fail_count;
        last_sig = signature;
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 0);
        check({tag, " fail_count_hold"}, 32'(fail_count), exp_fail);
    endtask

    initial begin
        logic [CW-1:0] fc_a;
        logic [15:0]   sig_a;
        int            n, fk, wait_k, done_seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({pat_ready, scan_enable, scan_in, dut_inp, busy, done, fail,
                                    fail_count, pat_idx}), 0);
        check("reset signature", 32'(signature), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        pd[0] = 3'b001; ppi[0] = 1'b0; pex[0] = 3'b000;
        do_run(1, 99, 0, -1, 1'b0, "clean_001");

        pd[0] = 3'b010; ppi[0] = 1'b0; pex[0] = 3'b001;
        do_run(1, 99, 0, 1, 1'b0, "q1_sa0");
        check("q1_sa0 fail_count_is_1", 32'(fail_count), 1);

        do_run(0, 99, 0, -1, 1'b0, "zero_patterns");

        fill(4, 30);
        do_run(4, 99, 0, 2, 1'b0, "four_nostall");
        fc_a = last_fc; sig_a = last_sig;
        do_run(4, 1, 5, 2, 1'b0, "four_stall");
        check("stall_vs_nostall fail_count", 32'(last_fc), 32'(fc_a));
        check("stall_vs_nostall signature", 32'(last_sig), 32'(sig_a));

        for (int t = 0; t < 6; t++) begin
            n  = $urandom_range(1, 8);
            fk = $urandom_range(0, 3) - 1;
            fill(n, 20);
            do_run(n, (t == 2) ? $urandom_range(0, n - 1) : 99, 3, fk, t == 1, "random");
        end

        // Abort in the middle of a load; outputs must drop at once and no done may follow.
        fill(3, 0);
        stuck_mask = '0;
        start = 1'b1; num_patterns = 5'd3; pat_valid = 1'b1;
        pat_data = pd[0]; pat_pi = ppi[0]; pat_exp = pex[0];
        @(posedge clk); #1;
        start = 1'b0;
        wait_k = 0;
        while (!scan_enable && wait_k < 20) begin
            @(posedge clk); #1;
            wait_k++;
        end
        check("midrun reached_shift", 32'(scan_enable), 1);
        rst = 1'b0;
        #1;
        check("midrun reset outputs", 32'({pat_ready, scan_enable, scan_in, dut_inp, busy, done, fail,
                                           fail_count, pat_idx}), 0);
        check("midrun reset signature", 32'(signature), 0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            done_seen += int'(done) + int'(busy);
        end
        pat_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            done_seen += int'(done) + int'(busy);
        end
        check("midrun no_done_no_busy", done_seen, 0);

        fill(2, 50);
        do_run(2, 99, 0, 0, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
